// File: rtl/burst_arbiter_if.sv
// Bundle between the burst arbiter, its requesters and the burst controller.
// Latency: none; wires only.
// Backpressure: none; the arbiter drives grants, and the controller ends a burst with burst_done.
interface burst_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [4*NUM_REQ-1:0] req_len;
    logic [2*NUM_REQ-1:0] req_mode;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic                 start_burst;
    logic [3:0]           burst_length;
    logic [1:0]           burst_mode;
    logic                 burst_done;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic                 timeout_err;

    // Arbiter side.
    modport master (
        input  req, req_len, req_mode, burst_done,
        output gnt, done, start_burst, burst_length, burst_mode,
               grant_id, busy, timeout_err
    );

    // Requester and controller side.
    modport slave (
        output req, req_len, req_mode, burst_done,
        input  gnt, done, start_burst, burst_length, burst_mode,
               grant_id, busy, timeout_err
    );
endinterface

// File: rtl/burst_arbiter.sv
// Round-robin arbiter that shares one burst controller; optional watchdog via BURST_ARB_TIMEOUT_EN.
// Latency: grant 1 cycle after req is sampled in idle, start_burst 1 cycle later, done 1 cycle after burst_done.
// Backpressure: the grant is held until burst_done (or a watchdog expiry); req is only looked at while idle.
module burst_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int MAX_WAIT = 255
) (
    input  logic          clk,
    input  logic          rst,
    burst_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]                 state;
    logic [ID_W-1:0]            rr_ptr;
    logic [NUM_REQ-1:0]         gnt_q;
    logic [NUM_REQ-1:0]         done_q;
    logic                       start_q;
    logic [3:0]                 len_q;
    logic [1:0]                 mode_q;
    logic [ID_W-1:0]            gid_q;
    logic                       busy_q;

    logic [NUM_REQ-1:0][3:0]    len_arr;
    logic [NUM_REQ-1:0][1:0]    mode_arr;
    logic                       win_vld;
    logic [ID_W-1:0]            win_id;
    logic [ID_W-1:0]            idx_w;
    int                         idx;

    assign len_arr  = bus.req_len;
    assign mode_arr = bus.req_mode;

    // Winner is the first pending request after the last owner, wrapping at NUM_REQ.
    always_comb begin
        win_vld = 1'b0;
        win_id  = rr_ptr;
        idx     = 0;
        idx_w   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_w = ID_W'(idx);
            if (!win_vld && bus.req[idx_w]) begin
                win_vld = 1'b1;
                win_id  = idx_w;
            end
        end
    end

`ifdef BURST_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       terr_q;
`endif

    // Arbitration state machine; every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rr_ptr  <= ID_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            len_q   <= '0;
            mode_q  <= '0;
            gid_q   <= ID_W'(NUM_REQ - 1);
            busy_q  <= 1'b0;
`ifdef BURST_ARB_TIMEOUT_EN
            wait_cnt <= '0;
            terr_q   <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        gnt_q  <= NUM_REQ'(1) << win_id;
                        gid_q  <= win_id;
                        rr_ptr <= win_id;
                        len_q  <= len_arr[win_id];
                        mode_q <= mode_arr[win_id];
                        busy_q <= 1'b1;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    start_q <= 1'b1;
                    state   <= S_WAIT;
`ifdef BURST_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (bus.burst_done) begin
                        gnt_q  <= '0;
                        done_q <= NUM_REQ'(1) << gid_q;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
`ifdef BURST_ARB_TIMEOUT_EN
                    else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                        // Controller never answered: release the owner and flag it.
                        gnt_q  <= '0;
                        done_q <= NUM_REQ'(1) << gid_q;
                        busy_q <= 1'b0;
                        terr_q <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.done         = done_q;
    assign bus.start_burst  = start_q;
    assign bus.burst_length = len_q;
    assign bus.burst_mode   = mode_q;
    assign bus.grant_id     = gid_q;
    assign bus.busy         = busy_q;
`ifdef BURST_ARB_TIMEOUT_EN
    assign bus.timeout_err  = terr_q;
`else
    assign bus.timeout_err  = 1'b0;
`endif
endmodule
